sp_fifo: RTL
============

# sp_fifo

Synchronous first-word-fall-through FIFO that uses one single-port, asynchronous-read RAM as storage, plus a one-word output register. It sits between a byte producer and a byte consumer, e.g. UART RX deserializer to host reader, or host writer to UART TX serializer. Push has priority on the single RAM port. Head data is held in a register, so `rd_data` is always registered and stable.

## Interface
- `DATA_WIDTH`, 8: word width.
- `ADDR_WIDTH`, 8: RAM address width. RAM depth is `DEPTH = 2**ADDR_WIDTH`. Total capacity is `DEPTH+1`.
- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `wr_en`  in  1: push request.
- `wr_data`  in  DATA_WIDTH: push data.
- `full`  out  1: RAM storage full; a push is not accepted.
- `rd_en`  in  1: pop request; acknowledges the current `rd_data`.
- `rd_data`  out  DATA_WIDTH: head word, valid while `empty`=0.
- `empty`  out  1: no word in the output register.
- `count`  out  ADDR_WIDTH+1: words held (0..DEPTH+1).
- `overflow`  out  1: sticky error flag (see Configuration).
- `underflow`  out  1: sticky error flag (see Configuration).

## Operation
- State:
  - `wr_ptr`, `rd_ptr`: ADDR_WIDTH bits each, wrap modulo DEPTH.
  - `ram_count`: ADDR_WIDTH+1 bits, range 0..DEPTH.
  - `out_valid`, `out_reg`.
- Derived outputs:
  - `full = (ram_count == DEPTH)`.
  - `empty = !out_valid`.
  - `count = ram_count + out_valid`.
  - `rd_data = out_reg`.
- Per-cycle events:
  - `push = wr_en && !full`.
  - `pop = rd_en && out_valid`.
  - `slot = !out_valid || pop`.
- RAM port: address = `push ? wr_ptr : rd_ptr`. RAM write enable is asserted only for a push that goes to the RAM (not for a bypass).
- Priority, evaluated each cycle:
  1. Bypass: if `push && slot && ram_count==0`, then `out_reg<=wr_data` and `out_valid<=1`. No RAM write and no pointer change.
  2. Otherwise, push to RAM: if `push`, write RAM[`wr_ptr`], `wr_ptr++`, `ram_count++`.
  3. Refill: if `slot && ram_count>0 && !push`, then `out_reg<=RAM[rd_ptr]` (combinational read), `rd_ptr++`, `ram_count--`, `out_valid<=1`.
  4. Otherwise, if `pop`, then `out_valid<=0`.
- When a push accepted into the RAM coincides with a pending refill, the refill stalls. If that cycle also pops, `empty` rises for at least one cycle (one-cycle bubble). This is the required behaviour, not an error.
- A push while `full` is dropped and state is unchanged, even if `rd_en` is high that cycle.
- A pop while `empty` is ignored.
- Reset mid-operation discards all contents. RAM contents are not cleared, and stale data is never presented.

## Timing
- Reset values: `empty`=1, `full`=0, `count`=0, `rd_data`=0, `overflow`=0, `underflow`=0. Pointers are 0.
- Push into an empty FIFO: `rd_data` is valid and `empty`=0 on the next cycle (latency 1).
- Pop with words in the RAM and no concurrent push: the next word appears on the next cycle with no bubble.
- `full` and `count` update one cycle after the causing edge (registered state).

## Configuration
- `SP_FIFO_ERR_EN` defined:
  - `overflow` sets on `wr_en && full`.
  - `underflow` sets on `rd_en && empty`.
  - Both are sticky until `rst`.
- Not defined: `overflow` and `underflow` are tied to 0 and no flag registers are built. All other behaviour is identical.

## Structure
- Shared package `sp_fifo_pkg`:
  - Default width constants.
  - `DEPTH` derivation function.
  - Count-width helper (`ADDR_WIDTH+1`).
- Sub-module: one instance of the team's single-port async-read RAM (`RAM_SP_AR`) with matching `DATA_WIDTH`/`ADDR_WIDTH`. All control logic stays in `sp_fifo`.

## Test plan
All scenarios use `DATA_WIDTH`=8, `ADDR_WIDTH`=2 (DEPTH=4, capacity 5).
- Reset check: after `rst`, `empty`=1, `full`=0, `count`=0, `rd_data`=0x00.
- Bypass: push 0xA5 into an empty FIFO. Next cycle `rd_data`=0xA5, `empty`=0, `count`=1, and no RAM write occurs.
- Fill and drain:
  - Push 0x01..0x05 on consecutive cycles. Then `count`=5 and `full`=1.
  - A 6th push of 0x06 is dropped; `overflow`=1 with the macro defined.
  - Pop continuously: output is 0x01..0x05 with no bubble, then `empty`=1.
- Simultaneous push/pop with the RAM non-empty: push 0x10 and pop in the same cycle. Next cycle `empty`=1 for one cycle (bubble), then the old second word appears. The final drain order is preserved, ending with 0x10.
- Pointer wrap: run 10 push/pop pairs with values 0x20..0x29. Read-back order is exact across the pointer wrap at 4.
- Reset mid-operation: with 3 words held, assert `rst` for one cycle. Then `empty`=1 and `count`=0. A subsequent push of 0x77 reads back 0x77, not stale data.

Source files
------------

// File: rtl/sp_fifo_pkg.sv
// Shared constants and sizing helpers for sp_fifo and its storage RAM.
package sp_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 8;

  function automatic int depth_of(input int addr_width);
    return 1 << addr_width;
  endfunction

  // One extra bit so the count can hold DEPTH+1 (RAM plus output register).
  function automatic int count_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/sp_fifo_ram.sv
// Single-port RAM with synchronous write and asynchronous (combinational) read.
module RAM_SP_AR
  import sp_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = depth_of(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/sp_fifo.sv
// First-word-fall-through FIFO on a single-port async-read RAM plus a head register.
// Optional sticky overflow/underflow flags are built when SP_FIFO_ERR_EN is defined.
module sp_fifo
  import sp_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = depth_of(ADDR_WIDTH);
  localparam int CW    = count_width(ADDR_WIDTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         ram_count_q, ram_count_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_reg_q, out_reg_d;

  logic                  push, pop, slot, ram_empty;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign full      = (ram_count_q == DEPTH_C);
  assign empty     = !out_valid_q;
  assign count     = ram_count_q + CW'(out_valid_q);
  assign rd_data   = out_reg_q;

  assign push      = wr_en && !full;
  assign pop       = rd_en && out_valid_q;
  assign slot      = !out_valid_q || pop;
  assign ram_empty = (ram_count_q == '0);
  // Push owns the single port; a refill can only read when nothing is written.
  assign ram_addr  = push ? wr_ptr_q : rd_ptr_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ram_count_d = ram_count_q;
    out_valid_d = out_valid_q;
    out_reg_d   = out_reg_q;
    ram_we      = 1'b0;

    if (pop) out_valid_d = 1'b0;

    if (push && slot && ram_empty) begin
      out_reg_d   = wr_data;
      out_valid_d = 1'b1;
    end else if (push) begin
      ram_we      = 1'b1;
      wr_ptr_d    = wr_ptr_q + ADDR_WIDTH'(1);
      ram_count_d = ram_count_q + CW'(1);
    end else if (slot && !ram_empty) begin
      out_reg_d   = ram_rdata;
      out_valid_d = 1'b1;
      rd_ptr_d    = rd_ptr_q + ADDR_WIDTH'(1);
      ram_count_d = ram_count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_count_q <= '0;
      out_valid_q <= 1'b0;
      out_reg_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_count_q <= ram_count_d;
      out_valid_q <= out_valid_d;
      out_reg_q   <= out_reg_d;
    end
  end

`ifdef SP_FIFO_ERR_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_en && full)  overflow_q  <= 1'b1;
      if (rd_en && empty) underflow_q <= 1'b1;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  RAM_SP_AR #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (wr_data),
    .rdata_o (ram_rdata)
  );

endmodule
